// File: rtl/nrd_divider_seq.sv
// Sequential 8-bit unsigned non-restoring divider built around a 9-bit ripple parallel_adder.
// Optional macro NRD_DIV_ZERO_DETECT_EN short-circuits divide-by-zero and raises dbz.

module parallel_adder (
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic       cin,
    output logic [8:0] out_add,
    output logic       cout
);
    logic [9:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_fa
            assign out_add[gi]  = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[9];
endmodule

module nrd_divider_seq (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       dbz
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [8:0] a_reg, a_next;
    logic [8:0] m_reg, m_next;
    logic [7:0] q_reg, q_next;
    logic [3:0] count_reg, count_next;
    logic [7:0] quotient_reg, quotient_next;
    logic [7:0] remainder_reg, remainder_next;
    logic       dbz_reg, dbz_next;

    logic [8:0] add_a;
    logic [8:0] add_b;
    logic       add_cin;
    logic [8:0] add_sum;
    logic       sub;
    logic       unused_cout;

    parallel_adder u_adder (
        .a       (add_a),
        .b       (add_b),
        .cin     (add_cin),
        .out_add (add_sum),
        .cout    (unused_cout)
    );

    // Adder operand steering: subtract/add of the shifted remainder while iterating,
    // plain A + M during the correction step.
    always_comb begin
        sub     = ~a_reg[8];
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_reg)
            ITER: begin
                add_a   = {a_reg[7:0], q_reg[7]};
                add_b   = sub ? ~m_reg : m_reg;
                add_cin = sub;
            end
            CORRECT: begin
                add_a   = a_reg;
                add_b   = m_reg;
                add_cin = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        m_next         = m_reg;
        q_next         = q_reg;
        count_next     = count_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            // DONE accepts a new request too, so a held start runs back-to-back.
            IDLE, DONE: begin
                if (start) begin
                    a_next     = 9'd0;
                    q_next     = dividend;
                    m_next     = {1'b0, divisor};
                    count_next = 4'd0;
                    dbz_next   = 1'b0;
                    state_next = ITER;
                end else begin
                    state_next = IDLE;
                end
            end
            ITER: begin
`ifdef NRD_DIV_ZERO_DETECT_EN
                if (m_reg == 9'd0) begin
                    quotient_next  = 8'hFF;
                    remainder_next = q_reg;
                    dbz_next       = 1'b1;
                    state_next     = DONE;
                end else begin
                    a_next     = add_sum;
                    q_next     = {q_reg[6:0], ~add_sum[8]};
                    count_next = count_reg + 4'd1;
                    if (count_reg == 4'd7) begin
                        state_next = CORRECT;
                    end
                end
`else
                a_next     = add_sum;
                q_next     = {q_reg[6:0], ~add_sum[8]};
                count_next = count_reg + 4'd1;
                if (count_reg == 4'd7) begin
                    state_next = CORRECT;
                end
`endif
            end
            CORRECT: begin
                // A negative partial remainder gets the divisor added back once.
                if (a_reg[8]) begin
                    a_next         = add_sum;
                    remainder_next = add_sum[7:0];
                end else begin
                    remainder_next = a_reg[7:0];
                end
                quotient_next = q_reg;
                state_next    = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            m_reg         <= '0;
            q_reg         <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            m_reg         <= m_next;
            q_reg         <= q_next;
            count_reg     <= count_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign dbz       = dbz_reg;
endmodule

// File: tb/tb_nrd_divider_seq.sv
// Self-checking bench for nrd_divider_seq: directed table, corner sequences, random vs arithmetic model.
// Build with NRD_DIV_ZERO_DETECT_EN defined to check the divide-by-zero shortcut.

module tb_nrd_divider_seq;
    logic       clk;
    logic       rst_b;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    int vectors;
    int miscompares;

    nrd_divider_seq dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd;
        logic [7:0] ds;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones quotient and dividend remainder.
    task automatic ref_div(input logic [7:0] dd, input logic [7:0] ds,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic z, output int lat);
        if (ds == 8'd0) begin
            q = 8'hFF;
            r = dd;
        end else begin
            q = dd / ds;
            r = dd % ds;
        end
        z   = 1'b0;
        lat = 9;
`ifdef NRD_DIV_ZERO_DETECT_EN
        if (ds == 8'd0) begin
            z   = 1'b1;
            lat = 1;
        end
`endif
    endtask

    // Issues one request and returns at the negedge where done is seen (bounded).
    task automatic do_div(input logic [7:0] dd, input logic [7:0] ds, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = ds;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_checked(input string tag, input logic [7:0] dd, input logic [7:0] ds);
        logic [7:0] eq, er;
        logic       ez;
        int         elat, lat;
        ref_div(dd, ds, eq, er, ez, elat);
        do_div(dd, ds, lat);
        $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", tag, dd, ds, quotient, remainder, dbz, lat);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_quotient"}, int'(quotient), int'(eq));
        chk({tag, "_remainder"}, int'(remainder), int'(er));
        chk({tag, "_dbz"}, int'(dbz), int'(ez));
        @(negedge clk);
        chk({tag, "_done_single"}, int'(done), 0);
    endtask

    initial begin
        vec_t       table_v[10];
        int         lat;
        int         n_busy, n_done, first_done, second_done;
        logic [7:0] q1, r1, q2, r2, hold_q;
        logic [7:0] rdd, rds;

        vectors     = 0;
        miscompares = 0;
        rst_b       = 1'b0;
        start       = 1'b0;
        dividend    = 8'd0;
        divisor     = 8'd0;

        table_v[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
        table_v[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        table_v[2] = '{8'd7,   8'd200, 8'd0,   8'd7};
        table_v[3] = '{8'd200, 8'd0,   8'hFF,  8'd200};
        table_v[4] = '{8'd13,  8'd4,   8'd3,   8'd1};
        table_v[5] = '{8'd250, 8'd16,  8'd15,  8'd10};
        table_v[6] = '{8'd0,   8'd0,   8'hFF,  8'd0};
        table_v[7] = '{8'd255, 8'd255, 8'd1,   8'd0};
        table_v[8] = '{8'd0,   8'd5,   8'd0,   8'd0};
        table_v[9] = '{8'd1,   8'd255, 8'd0,   8'd1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(dbz), 0);
        $display("reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b", busy, done, quotient, remainder, dbz);
        rst_b = 1'b1;

        // Directed table with hand-written expectations
        for (int i = 0; i < 10; i++) begin
            int elat;
            int ez;
            elat = 9;
            ez   = 0;
`ifdef NRD_DIV_ZERO_DETECT_EN
            if (table_v[i].ds == 8'd0) begin
                elat = 1;
                ez   = 1;
            end
`endif
            do_div(table_v[i].dd, table_v[i].ds, lat);
            $display("table[%0d]: %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", i, table_v[i].dd, table_v[i].ds,
                     quotient, remainder, dbz, lat);
            chk("table_latency", lat, elat);
            chk("table_quotient", int'(quotient), int'(table_v[i].exp_q));
            chk("table_remainder", int'(remainder), int'(table_v[i].exp_r));
            chk("table_dbz", int'(dbz), ez);
            @(negedge clk);
            chk("table_done_single", int'(done), 0);
        end

        // Results hold between operations
        hold_q = quotient;
        repeat (5) @(negedge clk);
        chk("hold_quotient", int'(quotient), int'(hold_q));
        chk("hold_remainder", int'(remainder), 1);

        // busy width for 100 / 7
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start  = 1'b0;
        n_busy = 0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) n_busy++;
            if (done) n_done++;
            @(negedge clk);
        end
        $display("busy_width: busy cycles=%0d done pulses=%0d", n_busy, n_done);
        chk("busy_width", n_busy, 10);
        chk("busy_width_done_count", n_done, 1);

        // Start during ITER is ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);                  // edge N passed
        start = 1'b0;
        repeat (3) @(negedge clk);       // edges N+1..N+3 passed
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);                  // edge N+4 samples the stray start
        start  = 1'b0;
        n_done = 0;
        q1 = 8'd0; r1 = 8'd0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                n_done++;
                q1 = quotient;
                r1 = remainder;
            end
            @(negedge clk);
        end
        $display("ignored_start: q=%0d r=%0d done pulses=%0d", q1, r1, n_done);
        chk("ignored_start_quotient", int'(q1), 10);
        chk("ignored_start_remainder", int'(r1), 0);
        chk("ignored_start_done_count", n_done, 1);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_quotient", int'(quotient), 0);
        chk("midreset_remainder", int'(remainder), 0);
        $display("midreset: busy=%0b done=%0b q=%0d r=%0d", busy, done, quotient, remainder);
        #1;
        rst_b  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midreset_no_done", n_done, 0);
        run_checked("after_reset", 8'd9, 8'd3);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; dividend = 8'd13; divisor = 8'd4;
        @(negedge clk);
        dividend    = 8'd250; divisor = 8'd16;
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        q1 = 8'd0; r1 = 8'd0; q2 = 8'd0; r2 = 8'd0;
        for (int c = 1; c < 35; c++) begin
            if (n_done == 1 && c == first_done + 1) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = c; q1 = quotient; r1 = remainder;
                end else if (n_done == 2) begin
                    second_done = c; q2 = quotient; r2 = remainder;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("back_to_back: (%0d,%0d)@%0d (%0d,%0d)@%0d pulses=%0d", q1, r1, first_done, q2, r2,
                 second_done, n_done);
        chk("b2b_done_count", n_done, 2);
        chk("b2b_spacing", second_done - first_done, 10);
        chk("b2b_q1", int'(q1), 3);
        chk("b2b_r1", int'(r1), 1);
        chk("b2b_q2", int'(q2), 15);
        chk("b2b_r2", int'(r2), 10);

        // Randomized against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            rdd = 8'($urandom_range(0, 255));
            rds = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_checked("rand", rdd, rds);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
